// File: rtl/ram_sdp.sv
// ram_sdp
//   Simple dual-port RAM: one write port and one synchronous read port,
//   DSIZE x DEPTH. The read is registered and sees the old contents when it
//   addresses the word being written on the same edge.
//   The read register clears on Reset so the delayed output starts at zero.
// Ports
//   Clock   in   1       rising-edge clock
//   Reset   in   1       asynchronous, active-high; clears the read register only
//   we      in   1       write enable
//   waddr   in   ASIZE   write address
//   wdata   in   DSIZE   write data
//   re      in   1       read enable; read register holds when low
//   raddr   in   ASIZE   read address
//   rdata   out  DSIZE   registered read data
module ram_sdp #(
    parameter  int DSIZE = 6,
    parameter  int DEPTH = 16,
    localparam int ASIZE = $clog2(DEPTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             we,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic             re,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);

    logic [DSIZE-1:0] mem [DEPTH];
    logic [DSIZE-1:0] rdata_q, rdata_d;

    always_ff @(posedge Clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ram_var_delay_reader.sv
// ram_var_delay_reader
//   Variable-depth RAM delay line with a programmable read tap. Each accepted
//   Din sample is written into a circular RAM; Q returns the sample accepted
//   Delay samples earlier. Q_valid is only raised once that many samples have
//   been written since reset, so unwritten or pre-reset RAM words never show.
// Ports
//   Clock      in   1      rising-edge clock
//   Reset      in   1      asynchronous, active-high reset
//   Din        in   DSIZE  input sample
//   Din_valid  in   1      accept Din this cycle (shift enable)
//   Delay      in   ASIZE  requested delay in accepted samples; 0 acts as 1
//   Q          out  DSIZE  delayed sample, registered
//   Q_valid    out  1      Q holds a genuinely written sample, registered
module ram_var_delay_reader #(
    parameter  int DSIZE = 6,
    parameter  int DEPTH = 16,
    localparam int ASIZE = $clog2(DEPTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [DSIZE-1:0] Din,
    input  logic             Din_valid,
    input  logic [ASIZE-1:0] Delay,
    output logic [DSIZE-1:0] Q,
    output logic             Q_valid
);

    logic [ASIZE-1:0] wp_q, wp_d;
    logic [ASIZE-1:0] fill_q, fill_d;
    logic [ASIZE-1:0] delay_q, delay_d;
    logic             q_valid_q, q_valid_d;
    logic [ASIZE-1:0] rd_addr;

    always_comb begin
        delay_d   = (Delay == '0) ? ASIZE'(1) : Delay;
        wp_d      = wp_q;
        fill_d    = fill_q;
        q_valid_d = q_valid_q;
        // Tap address trails the write pointer; 1 <= delay_q <= DEPTH-1 keeps it
        // off the word being written this edge.
        rd_addr   = wp_q - delay_q;
        if (Din_valid) begin
            wp_d      = wp_q + ASIZE'(1);
            fill_d    = (fill_q == ASIZE'(DEPTH - 1)) ? fill_q : fill_q + ASIZE'(1);
            // fill_q counts samples already written before this one, so the
            // tap word is genuine exactly when fill_q reaches the delay.
            q_valid_d = (fill_q >= delay_q);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wp_q      <= '0;
            fill_q    <= '0;
            delay_q   <= ASIZE'(1);
            q_valid_q <= 1'b0;
        end else begin
            wp_q      <= wp_d;
            fill_q    <= fill_d;
            delay_q   <= delay_d;
            q_valid_q <= q_valid_d;
        end
    end

    ram_sdp #(
        .DSIZE(DSIZE),
        .DEPTH(DEPTH)
    ) u_ram (
        .Clock (Clock),
        .Reset (Reset),
        .we    (Din_valid),
        .waddr (wp_q),
        .wdata (Din),
        .re    (Din_valid),
        .raddr (rd_addr),
        .rdata (Q)
    );

    assign Q_valid = q_valid_q;

endmodule
